// File: rtl/swipt_pkg.sv
// Shared defaults, saturation limits and decoder state type for the SWIPT gate-drive decoder.
package swipt_pkg;

  localparam int PERIOD_W_DEF = 20;
  localparam int HIGH_W_DEF   = 12;
  localparam int LOCK_TOL_DEF = 4;
  localparam int LOCK_CNT_DEF = 3;
  localparam int AVG_DEPTH    = 4;

  localparam logic [PERIOD_W_DEF-1:0] PERIOD_MAX = {PERIOD_W_DEF{1'b1}};
  localparam logic [HIGH_W_DEF-1:0]   HIGH_MAX   = {HIGH_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } dec_state_t;

endpackage

// File: rtl/swipt_edge_sync.sv
// Two-flop synchronizer for one asynchronous gate signal, with a registered edge detector.
module swipt_edge_sync (
  input  logic clk,
  input  logic nrst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_dly;
  assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/swipt_out_decoder.sv
// Recovers period, OUT0 high time, lock, loss and shoot-through from the four SWIPT_OUT gate signals.
// Build option SWIPT_DEC_AVG_EN: report the sliding mean of the last four periods instead of single values.
//   state | meaning
//   IDLE  | disabled, counters held at 0
//   ARM   | waiting for the first OUT0 rise
//   MEAS  | counting between consecutive OUT0 rises
module swipt_out_decoder
  import swipt_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int HIGH_W   = HIGH_W_DEF,
  parameter int LOCK_TOL = LOCK_TOL_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                swiptAlive,
  input  logic                SWIPT_OUT0,
  input  logic                SWIPT_OUT1,
  input  logic                SWIPT_OUT2,
  input  logic                SWIPT_OUT3,
  output logic [PERIOD_W-1:0] meas_period,
  output logic [HIGH_W-1:0]   meas_high,
  output logic                meas_valid,
  output logic                locked,
  output logic                lost,
  output logic                shoot_err
);

  localparam int                  LC_W   = $clog2(LOCK_CNT + 1);
  localparam logic [PERIOD_W-1:0] P_MAX  = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] P_ONE  = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] P_TOL  = PERIOD_W'(LOCK_TOL);
  localparam logic [HIGH_W-1:0]   H_MAX  = {HIGH_W{1'b1}};
  localparam logic [HIGH_W-1:0]   H_ONE  = HIGH_W'(1);
  localparam logic [LC_W-1:0]     LC_MAX = LC_W'(LOCK_CNT);
  localparam logic [LC_W-1:0]     LC_ONE = LC_W'(1);

  logic [3:0] w_raw;
  logic [3:0] w_sync;
  logic [3:0] w_rise;
  logic [3:0] w_fall;
  logic       w_unused_edges;

  assign w_raw = {SWIPT_OUT3, SWIPT_OUT2, SWIPT_OUT1, SWIPT_OUT0};

  for (genvar g = 0; g < 4; g++) begin : g_sync
    swipt_edge_sync u_sync (
      .clk     (clk),
      .nrst    (nrst),
      .i_async (w_raw[g]),
      .o_sync  (w_sync[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  // Only OUT0 edges drive timing; the other pairs are checked by level only.
  assign w_unused_edges = ^{w_rise[3:1], w_fall[3:1]};

  dec_state_t r_state;
  dec_state_t w_state_nxt;
  logic       w_start;
  logic       w_capture;
  logic       w_lost;

  logic [PERIOD_W-1:0] r_period_cnt;
  logic [HIGH_W-1:0]   r_high_cnt;
  logic                r_high_run;

  always_ff @(posedge clk) begin
    if (nrst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_lost      = 1'b0;
    if (!swiptAlive) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = ARM;
        ARM: begin
          if (w_rise[0]) begin
            w_start     = 1'b1;
            w_state_nxt = MEAS;
          end
        end
        MEAS: begin
          if (w_rise[0]) begin
            w_capture = 1'b1;
          end else if (r_period_cnt == P_MAX) begin
            w_lost      = 1'b1;
            w_state_nxt = ARM;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_high_run   <= 1'b0;
    end else if (w_start || w_capture) begin
      r_period_cnt <= P_ONE;
      r_high_cnt   <= H_ONE;
      r_high_run   <= 1'b1;
    end else if (r_state == MEAS && w_state_nxt == MEAS) begin
      r_period_cnt <= r_period_cnt + P_ONE;
      if (r_high_run && w_sync[0] && r_high_cnt != H_MAX) r_high_cnt <= r_high_cnt + H_ONE;
      if (w_fall[0]) r_high_run <= 1'b0;
    end else begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_high_run   <= 1'b0;
    end
  end

  logic [PERIOD_W-1:0] r_prev_period;
  logic [PERIOD_W-1:0] w_diff;
  logic                r_has_prev;
  logic                w_consistent;
  logic [LC_W-1:0]     r_cons;
  logic [LC_W-1:0]     w_cons_nxt;
  logic                r_locked;

  always_comb begin
    w_diff       = (r_period_cnt >= r_prev_period) ? (r_period_cnt - r_prev_period)
                                                   : (r_prev_period - r_period_cnt);
    w_consistent = r_has_prev && (w_diff <= P_TOL);
    w_cons_nxt   = '0;
    if (w_consistent) w_cons_nxt = (r_cons == LC_MAX) ? r_cons : r_cons + LC_ONE;
  end

  // Lock always tracks the raw period, even when the reported value is averaged.
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_prev_period <= '0;
      r_has_prev    <= 1'b0;
      r_cons        <= '0;
      r_locked      <= 1'b0;
    end else if (w_capture) begin
      r_prev_period <= r_period_cnt;
      r_has_prev    <= 1'b1;
      r_cons        <= w_cons_nxt;
      r_locked      <= (w_cons_nxt == LC_MAX);
    end else if (w_state_nxt != MEAS) begin
      r_has_prev <= 1'b0;
      r_cons     <= '0;
      r_locked   <= 1'b0;
    end
  end

  logic [PERIOD_W-1:0] r_meas_period;
  logic [HIGH_W-1:0]   r_meas_high;
  logic                r_valid;

`ifdef SWIPT_DEC_AVG_EN
  logic [PERIOD_W-1:0] r_pwin [AVG_DEPTH];
  logic [HIGH_W-1:0]   r_hwin [AVG_DEPTH];
  logic [PERIOD_W+1:0] r_psum;
  logic [PERIOD_W+1:0] w_psum_nxt;
  logic [HIGH_W+1:0]   r_hsum;
  logic [HIGH_W+1:0]   w_hsum_nxt;
  logic [2:0]          r_nwin;

  assign w_psum_nxt = r_psum + {2'b00, r_period_cnt} - {2'b00, r_pwin[AVG_DEPTH-1]};
  assign w_hsum_nxt = r_hsum + {2'b00, r_high_cnt}   - {2'b00, r_hwin[AVG_DEPTH-1]};

  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        r_pwin[i] <= '0;
        r_hwin[i] <= '0;
      end
      r_psum        <= '0;
      r_hsum        <= '0;
      r_nwin        <= '0;
      r_meas_period <= '0;
      r_meas_high   <= '0;
      r_valid       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_capture) begin
        r_pwin[0] <= r_period_cnt;
        r_hwin[0] <= r_high_cnt;
        for (int i = 1; i < AVG_DEPTH; i++) begin
          r_pwin[i] <= r_pwin[i-1];
          r_hwin[i] <= r_hwin[i-1];
        end
        r_psum <= w_psum_nxt;
        r_hsum <= w_hsum_nxt;
        if (r_nwin >= 3'(AVG_DEPTH - 1)) begin
          r_valid       <= 1'b1;
          r_meas_period <= w_psum_nxt[PERIOD_W+1:2];
          r_meas_high   <= w_hsum_nxt[HIGH_W+1:2];
        end
        if (r_nwin != 3'(AVG_DEPTH)) r_nwin <= r_nwin + 3'd1;
      end else if (w_state_nxt != MEAS) begin
        for (int i = 0; i < AVG_DEPTH; i++) begin
          r_pwin[i] <= '0;
          r_hwin[i] <= '0;
        end
        r_psum <= '0;
        r_hsum <= '0;
        r_nwin <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_meas_period <= '0;
      r_meas_high   <= '0;
      r_valid       <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_meas_period <= r_period_cnt;
        r_meas_high   <= r_high_cnt;
      end
    end
  end
`endif

  logic r_lost;
  logic r_shoot;

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_lost  <= 1'b0;
      r_shoot <= 1'b0;
    end else begin
      r_lost  <= w_lost;
      r_shoot <= r_shoot | (w_sync[0] & w_sync[1]) | (w_sync[2] & w_sync[3]);
    end
  end

  assign meas_period = r_meas_period;
  assign meas_high   = r_meas_high;
  assign meas_valid  = r_valid;
  assign locked      = r_locked;
  assign lost        = r_lost;
  assign shoot_err   = r_shoot;

endmodule
